// File: rtl/serial_addsub_core.sv
// serial_addsub_core
//   Bit-serial A + Bcom + m, LSB first, one bit per clock. A single full-adder
//   cell is reused for every bit position; results are presented with a
//   start/busy/done handshake.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     start  request, sampled only while busy=0
//     m      mode bit (0=add, 1=subtract), used as the initial carry-in
//     a      operand A
//     bcom   conditioned B operand (B, or ~B when m=1)
//     busy   high while an operation is in progress
//     done   one-cycle pulse when the result outputs update
//     sum    registered result (modulo 2^WIDTH)
//     cout   carry out of the MSB (subtract: 1 = no borrow)
//     ovf    signed overflow (carry into MSB XOR carry out of MSB)
//     zero   high when sum == 0

// Shared full-adder cell.
module serial_addsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bcom,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
    logic             c, s_bit, c_nxt;
    logic [CW-1:0]    cnt;
    logic             last, accept;

    serial_addsub_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (c),
        .s  (s_bit),
        .co (c_nxt)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    assign res_nxt = {s_bit, res_sr[WIDTH-1:1]};
    assign busy    = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= bcom;
                res_sr <= '0;
                c      <= m;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= res_nxt;
                c      <= c_nxt;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    // On the MSB step, c is the carry into the MSB and
                    // c_nxt the carry out; their XOR is signed overflow.
                    sum  <= res_nxt;
                    cout <= c_nxt;
                    ovf  <= c ^ c_nxt;
                    zero <= ~|res_nxt;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_core.sv
module tb_serial_addsub_core;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, start, m;
    logic [W-1:0] a, bcom;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] sum;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    serial_addsub_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .m     (m),
        .a     (a),
        .bcom  (bcom),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
        res_t        r;
        logic [W:0]  t;
        t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".sum"},  32'(sum),  32'(e.sum));
        chk({tag, ".cout"}, 32'(cout), 32'(e.cout));
        chk({tag, ".ovf"},  32'(ovf),  32'(e.ovf));
        chk({tag, ".zero"}, 32'(zero), 32'(e.zero));
    endtask

    // Runs one operation. Inputs are scrambled during RUN; if poke >= 0 a
    // second start with other operands is raised at that cycle. Returns at
    // the done cycle (1 time unit after the completion edge).
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tm, input int poke);
        res_t e;
        int   cyc;
        e     = model(ta, tb, tm);
        a     = ta;
        bcom  = tb;
        m     = tm;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
        chk({tag, ".done_e0"}, 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < 3 * W) begin
            if (!busy) chk({tag, ".busy_run"}, 32'(busy), 32'd1);
            a     = W'($urandom);
            bcom  = W'($urandom);
            m     = 1'($urandom);
            start = (cyc == poke);
            step();
            cyc++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(cyc), 32'(W));
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk_res(tag, e);
    endtask

    // One more idle cycle: done must have dropped and results must hold.
    task automatic chk_idle(input string tag, input res_t e);
        step();
        chk({tag, ".done_fall"}, 32'(done), 32'd0);
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
        chk_res({tag, ".hold"}, e);
    endtask

    initial begin
        res_t e;
        rst_n = 1'b0;
        start = 1'b0;
        m     = 1'b0;
        a     = '0;
        bcom  = '0;
        step();
        step();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk_res("rst", '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        rst_n = 1'b1;
        step();

        // Directed cases
        do_op("add5p3", 4'd5, 4'd3, 1'b0, -1);
        chk_idle("add5p3", model(4'd5, 4'd3, 1'b0));
        chk("add5p3.sum_lit", 32'(sum), 32'd8);
        chk("add5p3.ovf_lit", 32'(ovf), 32'd1);
        do_op("sub5m5", 4'd5, 4'b1010, 1'b1, -1);
        chk("sub5m5.zero_lit", 32'(zero), 32'd1);
        chk_idle("sub5m5", model(4'd5, 4'b1010, 1'b1));
        do_op("sub3m5", 4'd3, 4'b1010, 1'b1, -1);
        chk("sub3m5.sum_lit", 32'(sum), 32'hE);
        chk_idle("sub3m5", model(4'd3, 4'b1010, 1'b1));
        do_op("wrap15p1", 4'd15, 4'd1, 1'b0, -1);
        chk_idle("wrap15p1", model(4'd15, 4'd1, 1'b0));
        do_op("wrap8p8", 4'd8, 4'd8, 1'b0, -1);
        chk_idle("wrap8p8", model(4'd8, 4'd8, 1'b0));

        // Start raised mid-operation must be ignored
        do_op("ignore", 4'd6, 4'd7, 1'b0, 1);
        chk_idle("ignore", model(4'd6, 4'd7, 1'b0));

        // Back-to-back: second start issued in the done cycle
        do_op("b2b1", 4'd2, 4'd9, 1'b0, -1);
        do_op("b2b2", 4'd12, 4'd4, 1'b1, -1);
        chk_idle("b2b2", model(4'd12, 4'd4, 1'b1));

        // Reset two cycles into an operation (previous result is nonzero)
        do_op("pre_rst", 4'd5, 4'd3, 1'b0, -1);
        a     = 4'd7;
        bcom  = 4'd7;
        m     = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk_res("abort", '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (done || busy) chk("abort.quiet", 32'({busy, done}), 32'd0);
        end
        do_op("post_rst", 4'd9, 4'd9, 1'b0, -1);
        chk_idle("post_rst", model(4'd9, 4'd9, 1'b0));

        // Randomized operations, some back-to-back
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            logic         rm;
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            do_op("rand", ra, rb, rm, -1);
            if ($urandom_range(0, 1) == 0) begin
                e = model(ra, rb, rm);
                chk_idle("rand", e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
